norm_divider: RTL and testbench

Multi-cycle 32-bit integer divider for DIV/DIVU that reuses the leading-zero-count units to skip quotient bits that must be zero. It drives operand magnitudes to two external CLZ instances and consumes their 32-bit counts. From the counts it pre-aligns the divisor and runs only the needed restoring iterations. It sits in the execute stage beside the ALU, and its quotient and remainder feed the HI/LO registers.

---
 rtl/norm_divider.sv | 118 +++++++++++
 tb/tb_norm_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/norm_divider.sv
// Multi-cycle 32-bit DIV/DIVU divider; uses external CLZ counts to pre-align the
// divisor so only the quotient bits that can be non-zero are iterated.
module norm_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] clz_a_src,
  output logic [31:0] clz_b_src,
  input  logic [31:0] clz_a_cnt,
  input  logic [31:0] clz_b_cnt,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        dbz
);

  // state | meaning
  // IDLE  | wait for start, latch magnitudes and pick shortcut or iteration
  // CALC  | one restoring step per cycle, iter counts down to zero
  // SIGN  | apply sign fix-up and register q/r/dbz
  // DONE  | one-cycle done pulse
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state;
  logic [31:0] rem_w;
  logic [31:0] quo_w;
  logic [32:0] div_w;
  logic [5:0]  iter;
  logic        sign_q;
  logic        sign_r;
  logic        dbz_w;

  logic        neg_a;
  logic        neg_b;
  logic [5:0]  clz_a;
  logic [5:0]  clz_b;
  logic [5:0]  shift_k;
  logic        rem_ge;
  logic        unused_cnt_bits;

  assign neg_a     = is_signed & dividend[31];
  assign neg_b     = is_signed & divisor[31];
  // Two's-complement negate; 0x80000000 maps to itself, which is its unsigned magnitude.
  assign clz_a_src = neg_a ? (32'd0 - dividend) : dividend;
  assign clz_b_src = neg_b ? (32'd0 - divisor) : divisor;
  assign clz_a     = clz_a_cnt[5:0];
  assign clz_b     = clz_b_cnt[5:0];
  assign shift_k   = clz_b - clz_a;
  assign rem_ge    = {1'b0, rem_w} >= div_w;
  assign unused_cnt_bits = ^{clz_a_cnt[31:6], clz_b_cnt[31:6]};

  assign busy = (state == ST_CALC) || (state == ST_SIGN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rem_w  <= '0;
      quo_w  <= '0;
      div_w  <= '0;
      iter   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dbz_w  <= 1'b0;
      q      <= '0;
      r      <= '0;
      dbz    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sign_q <= neg_a ^ neg_b;
            sign_r <= neg_a;
            dbz_w  <= 1'b0;
            quo_w  <= '0;
            rem_w  <= clz_a_src;
            if (clz_b_src == 32'd0) begin
              quo_w  <= 32'hFFFF_FFFF;
              rem_w  <= dividend;
              sign_q <= 1'b0;
              sign_r <= 1'b0;
              dbz_w  <= 1'b1;
              state  <= ST_SIGN;
            end else if (clz_a > clz_b) begin
              state <= ST_SIGN;
            end else begin
              div_w <= {1'b0, clz_b_src} << shift_k;
              iter  <= shift_k + 6'd1;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (rem_ge) rem_w <= rem_w - div_w[31:0];
          quo_w <= {quo_w[30:0], rem_ge};
          div_w <= div_w >> 1;
          iter  <= iter - 6'd1;
          if (iter == 6'd1) state <= ST_SIGN;
        end
        ST_SIGN: begin
          q     <= sign_q ? (32'd0 - quo_w) : quo_w;
          r     <= sign_r ? (32'd0 - rem_w) : rem_w;
          dbz   <= dbz_w;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_divider.sv
// Scoreboard bench for norm_divider: directed divides with hand-computed results,
// a behavioural CLZ pair, and a monitor checking busy/done timing and q/r/dbz.
module tb_norm_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] clz_a_src;
  logic [31:0] clz_b_src;
  logic [31:0] clz_a_cnt;
  logic [31:0] clz_b_cnt;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dbz;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  norm_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .clz_a_src (clz_a_src),
    .clz_b_src (clz_b_src),
    .clz_a_cnt (clz_a_cnt),
    .clz_b_cnt (clz_b_cnt),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] clz32(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return 32'(31 - i);
    end
    return 32'd32;
  endfunction

  always_comb begin
    clz_a_cnt = clz32(clz_a_src);
    clz_b_cnt = clz32(clz_b_src);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks busy every cycle of an outstanding op and results on done.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sb_q.size() > 0) begin
        int idx;
        idx = cyc - sb_q[0].t0;
        chk({sb_q[0].name, " busy"}, 32'(busy), 32'((idx >= 1) && (idx <= sb_q[0].lat - 1)));
        if (done) begin
          chk({sb_q[0].name, " latency"}, 32'(idx), 32'(sb_q[0].lat));
          chk({sb_q[0].name, " q"}, q, sb_q[0].q);
          chk({sb_q[0].name, " r"}, r, sb_q[0].r);
          chk({sb_q[0].name, " dbz"}, 32'(dbz), 32'(sb_q[0].dbz));
          void'(sb_q.pop_front());
        end else if (idx > sb_q[0].lat + 2) begin
          chk({sb_q[0].name, " done timeout"}, 32'(idx), 32'(sb_q[0].lat));
          void'(sb_q.pop_front());
        end
      end else if (done) begin
        chk("unexpected done", 32'(done), 32'd0);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic launch(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic ed, input int lat);
    exp_t e;
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    e.q = eq; e.r = er; e.dbz = ed; e.lat = lat; e.t0 = cyc; e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic run(input string name, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                     input logic ed, input int lat);
    launch(name, sgn, a, b, eq, er, ed, lat);
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset q", q, 32'd0);
    chk("reset r", r, 32'd0);
    chk("reset dbz", 32'(dbz), 32'd0);
    rst_n = 1'b1;

    run("divu 100/7",     1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 7);
    run("div -7/2",       1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 4);
    run("div 7/-2",       1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 4);
    run("divu 3/10",      1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 2);
    run("divu 0/5",       1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 2);
    run("divu 5/0",       1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 2);
    run("divu 9/3",       1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 5);
    run("divu max/1",     1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34);
    run("div min/-1",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34);

    // A start in cycle 3 of a running divide must be dropped.
    launch("divu 100/7 ign", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 7);
    @(negedge clk);
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    // Abort a long divide with reset in cycle 4; no done may follow.
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'hFFFF_FFFF;
    divisor   = 32'd1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort q", q, 32'd0);
    chk("abort r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    run("divu 1000/10",   1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 9);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
